// File: rtl/dp_packetizer.sv
// rtl/dp_packetizer.sv - builds NoC packets from pixel and filter words
//
// Purpose:
//   Transmit-side packetizer for a PE. Two local sources offer words:
//   pixel words (5 elements) and filter words (3 elements). Each word is
//   tagged with a destination router address. A round-robin arbiter picks
//   one source. The chosen word is formatted into a packet and loaded into
//   a single output holding register. The register reloads in the same
//   cycle that the router takes the current packet, so sustained throughput
//   is one packet per clock.
//
// Packet layout (defaults, PWIDTH = 47):
//   [46]    type, 1 = pixel, 0 = filter
//   [45:43] destination address
//   [42:40] SRC_ADDR
//   [39:0]  pixel payload, or {16'h0, 24-bit filter payload}
//
// Ports:
//   i_clk          clock, rising edge
//   i_reset        asynchronous active-high reset
//   i_pix_valid    pixel word offered
//   o_pix_ready    pixel word accepted when i_pix_valid && o_pix_ready
//   i_pix_data     five pixels, first pixel in the top byte
//   i_pix_dest     destination address of the pixel word
//   i_filt_valid   filter word offered
//   o_filt_ready   filter word accepted when i_filt_valid && o_filt_ready
//   i_filt_data    three filter weights
//   i_filt_dest    destination address of the filter word
//   o_pkt_valid    o_pkt_data holds a packet
//   i_pkt_ready    router takes the packet
//   o_pkt_data     packet
//   o_pix_cnt      accepted pixel handshakes, wraps at 16 bits (PKT_STATS_EN only)
//   o_filt_cnt     accepted filter handshakes, wraps at 16 bits (PKT_STATS_EN only)
//
// Build option:
//   PKT_STATS_EN   adds the handshake counters, plus a simulation print
//                  for each packet the router takes.

module dp_packetizer #(
  parameter int unsigned         DWIDTH   = 8,
  parameter int unsigned         PWIDTH   = 47,
  parameter int unsigned         AWIDTH   = 3,
  parameter logic [AWIDTH-1:0]   SRC_ADDR = 3'b000
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_pix_valid,
  output logic                   o_pix_ready,
  input  logic [5*DWIDTH-1:0]    i_pix_data,
  input  logic [AWIDTH-1:0]      i_pix_dest,
  input  logic                   i_filt_valid,
  output logic                   o_filt_ready,
  input  logic [3*DWIDTH-1:0]    i_filt_data,
  input  logic [AWIDTH-1:0]      i_filt_dest,
`ifdef PKT_STATS_EN
  output logic [15:0]            o_pix_cnt,
  output logic [15:0]            o_filt_cnt,
`endif
  output logic                   o_pkt_valid,
  input  logic                   i_pkt_ready,
  output logic [PWIDTH-1:0]      o_pkt_data
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  typedef enum logic {
    SRC_FILT = 1'b0,
    SRC_PIX  = 1'b1
  } src_t;

  state_t              r_state;
  src_t                r_last_grant;
  logic                r_pkt_valid;
  logic [PWIDTH-1:0]   r_pkt_data;

  logic                w_can_load;
  logic                w_grant_pix;
  logic                w_grant_filt;
  logic                w_load;
  logic [PWIDTH-1:0]   w_pix_pkt;
  logic [PWIDTH-1:0]   w_filt_pkt;

  // The holding register can take a new packet when it is empty, or when
  // its current packet leaves in this same cycle.
  assign w_can_load = (r_state == ST_EMPTY) || i_pkt_ready;

  // Round robin. On a tie, the source that did not win last time is
  // granted. A lone requester always wins. The grant depends only on the
  // valids and on registered state, never on the readies.
  assign w_grant_pix  = i_pix_valid  && (!i_filt_valid || (r_last_grant == SRC_FILT));
  assign w_grant_filt = i_filt_valid && (!i_pix_valid  || (r_last_grant == SRC_PIX));

  assign o_pix_ready  = w_can_load && w_grant_pix;
  assign o_filt_ready = w_can_load && w_grant_filt;
  assign w_load       = o_pix_ready || o_filt_ready;

  // Filter payload is right-aligned. The two unused elements above it are zero.
  assign w_pix_pkt  = {1'b1, i_pix_dest,  SRC_ADDR, i_pix_data};
  assign w_filt_pkt = {1'b0, i_filt_dest, SRC_ADDR, {(2*DWIDTH){1'b0}}, i_filt_data};

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= ST_EMPTY;
      r_pkt_valid  <= 1'b0;
      r_pkt_data   <= '0;
      r_last_grant <= SRC_FILT;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_load) begin
            r_state      <= ST_FULL;
            r_pkt_valid  <= 1'b1;
            r_pkt_data   <= w_grant_pix ? w_pix_pkt : w_filt_pkt;
            r_last_grant <= w_grant_pix ? SRC_PIX : SRC_FILT;
          end
        end
        ST_FULL: begin
          if (w_load) begin
            // Back-to-back: the current packet leaves and the next one
            // replaces it, with no bubble.
            r_state      <= ST_FULL;
            r_pkt_valid  <= 1'b1;
            r_pkt_data   <= w_grant_pix ? w_pix_pkt : w_filt_pkt;
            r_last_grant <= w_grant_pix ? SRC_PIX : SRC_FILT;
          end else if (i_pkt_ready) begin
            r_state     <= ST_EMPTY;
            r_pkt_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_EMPTY;
          r_pkt_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_pkt_valid = r_pkt_valid;
  assign o_pkt_data  = r_pkt_data;

`ifdef PKT_STATS_EN
  logic [15:0] r_pix_cnt;
  logic [15:0] r_filt_cnt;

  // The counters wrap naturally at 16 bits.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_pix_cnt  <= '0;
      r_filt_cnt <= '0;
    end else begin
      if (i_pix_valid && o_pix_ready) begin
        r_pix_cnt <= r_pix_cnt + 16'd1;
      end
      if (i_filt_valid && o_filt_ready) begin
        r_filt_cnt <= r_filt_cnt + 16'd1;
      end
    end
  end

  assign o_pix_cnt  = r_pix_cnt;
  assign o_filt_cnt = r_filt_cnt;

  always @(posedge i_clk) begin
    if (!i_reset && r_pkt_valid && i_pkt_ready) begin
      $display("dp_packetizer emit type=%s dest=%0d time=%0t",
               r_pkt_data[PWIDTH-1] ? "pixel" : "filter",
               r_pkt_data[PWIDTH-2 -: AWIDTH], $time);
    end
  end
`endif

endmodule

// File: tb/tb_dp_packetizer.sv
// tb/tb_dp_packetizer.sv - self-checking bench for dp_packetizer

module tb_dp_packetizer;

    logic        clk;
    logic        reset;
    logic        pix_valid;
    logic        pix_ready;
    logic [39:0] pix_data;
    logic [2:0]  pix_dest;
    logic        filt_valid;
    logic        filt_ready;
    logic [23:0] filt_data;
    logic [2:0]  filt_dest;
    logic        pkt_valid;
    logic        pkt_ready;
    logic [46:0] pkt_data;
`ifdef PKT_STATS_EN
    logic [15:0] pix_cnt;
    logic [15:0] filt_cnt;
`endif

    int n_checks;
    int n_fail;

    bit          m_valid;
    logic [46:0] m_data;
    bit          m_pix_turn;
    bit          e_pr;
    bit          e_fr;

    int          hs_pix;
    int          hs_filt;
    logic [46:0] held;

    dp_packetizer dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_pix_valid  (pix_valid),
        .o_pix_ready  (pix_ready),
        .i_pix_data   (pix_data),
        .i_pix_dest   (pix_dest),
        .i_filt_valid (filt_valid),
        .o_filt_ready (filt_ready),
        .i_filt_data  (filt_data),
        .i_filt_dest  (filt_dest),
`ifdef PKT_STATS_EN
        .o_pix_cnt    (pix_cnt),
        .o_filt_cnt   (filt_cnt),
`endif
        .o_pkt_valid  (pkt_valid),
        .i_pkt_ready  (pkt_ready),
        .o_pkt_data   (pkt_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [46:0] pix_pkt(input logic [39:0] d, input logic [2:0] dst);
        return {1'b1, dst, 3'b000, d};
    endfunction

    function automatic logic [46:0] filt_pkt(input logic [23:0] d, input logic [2:0] dst);
        return {1'b0, dst, 3'b000, 16'h0000, d};
    endfunction

    task automatic step();
        bit want_pix;
        bit want_filt;
        bit room;
        #1;
        want_pix  = pix_valid;
        want_filt = filt_valid;
        if (want_pix && want_filt) begin
            want_pix  = m_pix_turn;
            want_filt = !m_pix_turn;
        end
        room = !m_valid || pkt_ready;
        e_pr = room && want_pix;
        e_fr = room && want_filt;
        chk("pix_ready", pix_ready, e_pr);
        chk("filt_ready", filt_ready, e_fr);
        chk("pkt_valid", pkt_valid, m_valid);
        if (m_valid) chk("pkt_data", pkt_data, m_data);
        @(posedge clk);
        if (e_pr) begin
            m_data = pix_pkt(pix_data, pix_dest); m_valid = 1; m_pix_turn = 0; hs_pix++;
        end else if (e_fr) begin
            m_data = filt_pkt(filt_data, filt_dest); m_valid = 1; m_pix_turn = 1; hs_filt++;
        end else if (pkt_ready) begin
            m_valid = 0;
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        pix_valid = 0; filt_valid = 0;
        pix_data = '0; pix_dest = '0; filt_data = '0; filt_dest = '0;
    endtask

    task automatic model_reset();
        m_valid = 0; m_data = '0; m_pix_turn = 1;
    endtask

    initial begin
        n_checks = 0; n_fail = 0; hs_pix = 0; hs_filt = 0;
        reset = 1; pkt_ready = 1;
        idle_inputs();
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_pkt_valid", pkt_valid, 1'b0);
        chk("reset_pkt_data", pkt_data, 47'h0);
        reset = 0;

        pix_valid = 1; pix_data = 40'h0102030405; pix_dest = 3'b010;
        step();
        idle_inputs();
        #1;
        chk("pix_pkt_valid", pkt_valid, 1'b1);
        chk("pix_pkt_data", pkt_data, 47'h50_0102030405);
        step();
        chk("pix_pulse_end", pkt_valid, 1'b0);

        filt_valid = 1; filt_data = 24'h0A0B0C; filt_dest = 3'b101;
        step();
        idle_inputs();
        #1;
        chk("filt_pkt_data", pkt_data, 47'h28_00000A0B0C);
        step();

        hs_pix = 0; hs_filt = 0;
        for (int i = 0; i < 6; i++) begin
            pix_valid = 1; filt_valid = 1;
            pix_data = 40'({$urandom(), $urandom()}); pix_dest = 3'($urandom_range(0, 7));
            filt_data = 24'($urandom()); filt_dest = 3'($urandom_range(0, 7));
            #1;
            chk("alt_pix_grant", pix_ready, (i % 2 == 0) ? 1'b1 : 1'b0);
            step();
        end
        idle_inputs();
        chk("alt_pix_count", hs_pix, 3);
        chk("alt_filt_count", hs_filt, 3);
        step();
        step();

        pkt_ready = 0; pix_valid = 1; pix_data = 40'hA1A2A3A4A5; pix_dest = 3'b111;
        step();
        held = pkt_data;
        pix_data = 40'hB1B2B3B4B5; pix_dest = 3'b011;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hold_data", pkt_data, held);
        end
        pkt_ready = 1;
        step();
        #1;
        chk("hold_release", pkt_data, pix_pkt(40'hB1B2B3B4B5, 3'b011));
        idle_inputs();

        pkt_ready = 0; filt_valid = 1; filt_data = 24'h123456; filt_dest = 3'b001;
        step();
        chk("pre_reset_full", pkt_valid, 1'b1);
        reset = 1;
        #1;
        chk("async_reset_valid", pkt_valid, 1'b0);
        chk("async_reset_data", pkt_data, 47'h0);
        @(negedge clk);
        reset = 0; pkt_ready = 1;
        model_reset();
        pix_valid = 1; filt_valid = 1;
        #1;
        chk("post_reset_tie_pix", pix_ready, 1'b1);
        step();
        idle_inputs();
        step();

        for (int i = 0; i < 400; i++) begin
            pix_valid  = 1'($urandom_range(0, 1));
            filt_valid = 1'($urandom_range(0, 1));
            pkt_ready  = ($urandom_range(0, 3) != 0);
            pix_data   = 40'({$urandom(), $urandom()});
            pix_dest   = 3'($urandom_range(0, 7));
            filt_data  = 24'($urandom());
            filt_dest  = 3'($urandom_range(0, 7));
            step();
        end
        idle_inputs();
        pkt_ready = 1;
        step();

`ifdef PKT_STATS_EN
        reset = 1;
        @(negedge clk);
        reset = 0;
        model_reset();
        chk("cnt_reset", pix_cnt, 16'd0);
        pix_valid = 1; pkt_ready = 1;
        for (int i = 0; i < 70000; i++) begin
            pix_data = 40'(i);
            @(negedge clk);
        end
        idle_inputs();
        @(negedge clk);
        chk("pix_cnt_wrap", pix_cnt, 16'd4464);
        chk("filt_cnt_zero", filt_cnt, 16'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dp_packetizer.md
Name: dp_packetizer

Overview:
- Transmit-side counterpart of the PE depacketizer.
- Accepts pixel words (40b) and filter words (24b) from local PE sources, each tagged with a destination router address.
- Builds 47-bit NoC packets and presents them on a single valid/ready output toward the router.
- Clocked RTL: one output holding register, round-robin arbitration between the two sources, back-to-back throughput of one packet per cycle.

Parameters:
- DWIDTH, 8, element width; pixel payload = 5*DWIDTH, filter payload = 3*DWIDTH.
- PWIDTH, 47, packet width; must equal 5*DWIDTH+7.
- AWIDTH, 3, router address width.
- SRC_ADDR, 3'b000, this PE's address, written into every packet's source field.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- pix_valid  in  1  pixel word offered.
- pix_ready  out  1  pixel word accepted this cycle when pix_valid && pix_ready.
- pix_data  in  5*DWIDTH  five pixels; [39:32] is the first pixel, [7:0] the last.
- pix_dest  in  AWIDTH  destination address for the pixel word.
- filt_valid  in  1  filter word offered.
- filt_ready  out  1  filter word accepted this cycle when filt_valid && filt_ready.
- filt_data  in  3*DWIDTH  three filter weights.
- filt_dest  in  AWIDTH  destination address for the filter word.
- pkt_valid  out  1  packet on pkt_data is valid.
- pkt_ready  in  1  router accepts the packet.
- pkt_data  out  PWIDTH  packet.

Behaviour:
- Packet format:
  - [46] type: 1 = pixel, 0 = filter.
  - [45:43] destination address.
  - [42:40] SRC_ADDR.
  - Pixel payload occupies [39:0].
  - Filter payload occupies [23:0]; [39:24] = 0.
- Reset: pkt_valid=0, pkt_data=0, last_grant=FILTER (so pixel wins the first tie). An asserted reset mid-transfer discards the held packet; no partial packet is ever emitted afterward.
- States:
  - EMPTY (pkt_valid=0).
  - FULL (pkt_valid=1).
- can_load = EMPTY || (FULL && pkt_ready).
- Grant (combinational):
  - Only pix_valid: pixel.
  - Only filt_valid: filter.
  - Both valid: the source opposite last_grant.
  - Neither: none.
- pix_ready = can_load && grant==pixel; filt_ready = can_load && grant==filter. At most one ready is high in any cycle. Ready may depend on valid, but neither valid may wait on ready.
- On a grant with can_load: register the formatted packet, go to or stay in FULL, and update last_grant. Latency is 1 cycle from input handshake to pkt_valid.
- FULL && pkt_ready && no grant: go to EMPTY.
- FULL && !pkt_ready: pkt_data and pkt_valid hold stable, both readies are 0, and no input is consumed.
- Sustained throughput is 1 packet/cycle when pkt_ready is held high. With both sources continuously valid, output strictly alternates pixel, filter, pixel, …
- A dest equal to SRC_ADDR is legal and is passed through unchanged.
- Inputs are sampled only at the handshake cycle; later changes do not affect the held packet.

Optional Feature:
- Macro PKT_STATS_EN.
- When defined:
  - Adds outputs pix_cnt and filt_cnt, 16b each. Each counts accepted input handshakes of its type.
  - Counters reset to 0 and wrap from 16'hFFFF to 0.
  - Adds a simulation $display per emitted packet showing type, dest and time.
- When undefined: those ports and that logic do not exist; all other behaviour is identical.

Test Plan:
- Reset, then pix_valid with data 40'h0102030405 and dest 3'b010, pkt_ready=1 → next cycle pkt_data = {1'b1, 3'b010, 3'b000, 40'h0102030405}; pkt_valid pulses for 1 cycle.
- filt_valid with data 24'h0A0B0C and dest 3'b101 → pkt_data = {1'b0, 3'b101, 3'b000, 16'h0, 24'h0A0B0C}.
- Both sources valid for 6 cycles with pkt_ready=1 → packet types P,F,P,F,P,F; exactly 3 handshakes per source.
- Packet held, pkt_ready=0 for 5 cycles with pix_valid=1 → pkt_data stable, pix_ready=0 throughout; pkt_ready=1 then gives the next packet the following cycle with no bubble.
- reset asserted asynchronously while FULL → pkt_valid drops immediately; after release the first tie grants pixel.
- PKT_STATS_EN: 70000 pixel handshakes → pix_cnt = 70000 mod 65536 = 4464.
